// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants, descriptor op enum and loader FSM states
// for the instruction encoder / imem loader.
package instr_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_ADDI    = 3'b000;
   localparam logic [2:0] F3_ORI     = 3'b110;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_SW      = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;
   localparam logic [2:0] F3_BLT     = 3'b100;
   localparam logic [2:0] F3_BGE     = 3'b101;
   localparam logic [2:0] F3_BLTU    = 3'b110;
   localparam logic [2:0] F3_BGEU    = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [4:0] {
      ADD  = 5'd0,  SUB  = 5'd1,  SLL  = 5'd2,  SLT  = 5'd3,  SLTU = 5'd4,
      XOR  = 5'd5,  SRL  = 5'd6,  SRA  = 5'd7,  OR   = 5'd8,  AND  = 5'd9,
      ADDI = 5'd10, ORI  = 5'd11, LW   = 5'd12, SW   = 5'd13,
      BEQ  = 5'd14, BNE  = 5'd15, BLT  = 5'd16, BGE  = 5'd17, BLTU = 5'd18,
      BGEU = 5'd19
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // True when imm[31:msb] is a pure sign extension.
   function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
      logic [31:0] hi;
      hi = $unsigned($signed(imm) >>> msb);
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor stream in, imem write port out. The encoder takes the slave
// modport; the loader/testbench side takes master.
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_op;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [31:0]       in_imm;
   logic              in_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational descriptor -> RV32I word packer; flags undefined ops and
// immediates that do not fit the instruction format.
module instr_field_pack
   import instr_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   op_e        opv;
   logic [2:0] r_f3;
   logic [2:0] b_f3;
   logic [6:0] r_f7;
   logic       fits_is;
   logic       fits_b;

   assign opv     = op_e'(op);
   assign fits_is = imm_fits(imm, 11);
   assign fits_b  = imm_fits(imm, 12) && !imm[0];
   assign r_f7    = (opv == SUB || opv == SRA) ? F7_ALT : F7_BASE;

   always_comb begin
      r_f3 = F3_ADD_SUB;
      case (opv)
         SLL:     r_f3 = F3_SLL;
         SLT:     r_f3 = F3_SLT;
         SLTU:    r_f3 = F3_SLTU;
         XOR:     r_f3 = F3_XOR;
         SRL:     r_f3 = F3_SRL_SRA;
         SRA:     r_f3 = F3_SRL_SRA;
         OR:      r_f3 = F3_OR;
         AND:     r_f3 = F3_AND;
         default: r_f3 = F3_ADD_SUB;
      endcase
   end

   always_comb begin
      b_f3 = F3_BEQ;
      case (opv)
         BNE:     b_f3 = F3_BNE;
         BLT:     b_f3 = F3_BLT;
         BGE:     b_f3 = F3_BGE;
         BLTU:    b_f3 = F3_BLTU;
         BGEU:    b_f3 = F3_BGEU;
         default: b_f3 = F3_BEQ;
      endcase
   end

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (opv)
         ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND:
            word = {r_f7, rs2, rs1, r_f3, rd, OP_R};
         ADDI: begin
            word    = {imm[11:0], rs1, F3_ADDI, rd, OP_IMM};
            illegal = !fits_is;
         end
         ORI: begin
            word    = {imm[11:0], rs1, F3_ORI, rd, OP_IMM};
            illegal = !fits_is;
         end
         LW: begin
            word    = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            illegal = !fits_is;
         end
         SW: begin
            word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
            illegal = !fits_is;
         end
         BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
            word    = {imm[12], imm[10:5], rs2, rs1, b_f3, imm[4:1], imm[11], OP_BRANCH};
            illegal = !fits_b;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Boot/test loader: encodes accepted descriptors and writes them one per
// cycle into imem starting at BASE_ADDR, up to DEPTH words per session.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   instr_encoder_if.slave    bus,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              done,
   output logic              err_illegal
);

   localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_M1 = (ADDR_W+1)'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   cnt_q;
   logic [ADDR_W:0]   cnt_pend;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic              ready;
   logic              clear;
   logic              accept;
   logic              wr_fire;
   logic [31:0]       word;
   logic              illegal;

   instr_field_pack u_pack (
      .op      (bus.in_op),
      .rd      (bus.in_rd),
      .rs1     (bus.in_rs1),
      .rs2     (bus.in_rs2),
      .imm     (bus.in_imm),
      .word    (word),
      .illegal (illegal)
   );

   // Counting the in-flight write lets ready fall right after the last slot is taken.
   assign cnt_pend = cnt_q + {{ADDR_W{1'b0}}, we_q};
   assign full     = (cnt_pend == DEPTH_C);
   assign accept   = bus.in_valid && ready;
   assign wr_fire  = accept && !illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      done    = 1'b0;
      clear   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               clear   = 1'b1;
            end
         end
         S_LOAD: begin
            ready = !full;
            if (bus.in_valid && !full &&
                (bus.in_last || (!illegal && cnt_pend == DEPTH_M1)))
               state_d = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               state_d = S_LOAD;
               clear   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= BASE_C;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         we_q <= wr_fire;
         if (wr_fire) begin
            addr_q  <= ptr_q;
            wdata_q <= word;
            ptr_q   <= ptr_q + 1'b1;
         end
         if (clear) begin
            ptr_q <= BASE_C;
            cnt_q <= '0;
            err_q <= 1'b0;
         end else begin
            cnt_q <= cnt_pend;
            if (accept && illegal) err_q <= 1'b1;
         end
      end
   end

   assign bus.in_ready   = ready;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign count          = cnt_q;
   assign err_illegal    = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed + randomized bench for instr_encoder; expected words come from an
// arithmetic model of the RV32I formats and a session-level loader model.
module tb_instr_encoder;

   localparam int ADDR_W = 8;
   localparam int BASE   = 254;
   localparam int DEPTH  = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [ADDR_W:0]  count;
   logic             full;
   logic             done;
   logic             err_illegal;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .bus         (bus),
      .count       (count),
      .full        (full),
      .done        (done),
      .err_illegal (err_illegal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Loader model state
   bit  m_load, m_done, m_err;
   int  m_ptr, m_count;
   bit  exp_we;
   int  exp_addr;
   logic [31:0] exp_data;
   bit  rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference encoder from format rules and signed ranges.
   function automatic logic [32:0] ref_enc(input int op, input int rd, input int rs1,
                                           input int rs2, input logic [31:0] imm);
      int r_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
      int b_f3[6]  = '{0, 1, 4, 5, 6, 7};
      int s, f3, w;
      bit ok;
      s  = $signed(imm);
      ok = 1'b1;
      w  = 0;
      if (op <= 9) begin
         w = ((op == 1 || op == 7) ? 32 : 0) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
           + r_f3[op] * (1 << 12) + rd * (1 << 7) + 'h33;
      end else if (op <= 12) begin
         ok = (s >= -2048) && (s <= 2047);
         f3 = (op == 10) ? 0 : (op == 11) ? 6 : 2;
         w  = ((s & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | ((op == 12) ? 'h03 : 'h13);
      end else if (op == 13) begin
         ok = (s >= -2048) && (s <= 2047);
         w  = (((s >>> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
            | ((s & 31) << 7) | 'h23;
      end else if (op <= 19) begin
         ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
         w  = (((s >>> 12) & 1) << 31) | (((s >>> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
            | (b_f3[op-14] << 12) | (((s >>> 1) & 15) << 8) | (((s >>> 11) & 1) << 7) | 'h63;
      end else begin
         ok = 1'b0;
      end
      return ok ? {1'b1, 32'(w)} : 33'd0;
   endfunction

   // One cycle: check outputs on the falling edge, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      chk("imem_we", 64'(bus.imem_we), 64'(exp_we));
      if (exp_we) begin
         chk("imem_addr", 64'(bus.imem_addr), 64'(exp_addr));
         chk("imem_wdata", 64'(bus.imem_wdata), 64'(exp_data));
      end
      chk("in_ready", 64'(bus.in_ready), 64'(m_load && m_count < DEPTH));
      chk("count", 64'(count), 64'(m_count - int'(exp_we)));
      chk("full", 64'(full), 64'(m_count == DEPTH));
      chk("done", 64'(done), 64'(m_done));
      chk("err_illegal", 64'(err_illegal), 64'(m_err));
      exp_we = 1'b0;
      rdy    = bus.in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      tick();
   endtask

   task automatic pulse_start();
      bus.in_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (!m_load) begin
         m_load = 1'b1; m_done = 1'b0; m_err = 1'b0; m_count = 0; m_ptr = BASE;
      end
   endtask

   task automatic model_reset();
      m_load = 1'b0; m_done = 1'b0; m_err = 1'b0; m_count = 0; m_ptr = BASE; exp_we = 1'b0;
   endtask

   task automatic send(input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input bit last, input logic [32:0] want,
                       input int wait_max, output bit acc);
      bus.in_valid = 1'b1;
      bus.in_op    = 5'(op);
      bus.in_rd    = 5'(rd);
      bus.in_rs1   = 5'(rs1);
      bus.in_rs2   = 5'(rs2);
      bus.in_imm   = imm;
      bus.in_last  = last;
      acc = 1'b0;
      for (int t = 0; t < wait_max && !acc; t++) begin
         tick();
         if (rdy) begin
            acc = 1'b1;
            if (want[32]) begin
               exp_we   = 1'b1;
               exp_addr = m_ptr;
               exp_data = want[31:0];
               m_ptr    = (m_ptr + 1) % (1 << ADDR_W);
               m_count++;
            end else begin
               m_err = 1'b1;
            end
            if (last || m_count == DEPTH) begin
               m_load = 1'b0;
               m_done = 1'b1;
            end
         end
      end
   endtask

   // Send expecting acceptance.
   task automatic put(input int op, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input bit last, input logic [32:0] want);
      bit acc;
      send(op, rd, rs1, rs2, imm, last, want, 8, acc);
      chk("accepted", 64'(acc), 64'd1);
   endtask

   function automatic logic [31:0] rand_imm();
      int b[9] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 0};
      case ($urandom_range(0, 3))
         0:       return 32'($signed($urandom_range(0, 4095)) - 2048);
         1:       return 32'($signed($urandom_range(0, 8191)) - 4096);
         2:       return $urandom();
         default: return 32'(b[$urandom_range(0, 8)]);
      endcase
   endfunction

   initial begin
      bit acc;
      int op, rd, rs1, rs2;
      logic [31:0] imm;

      rst = 1'b1; start = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
      bus.in_rs2 = '0; bus.in_imm = '0; bus.in_last = 1'b0;
      model_reset();
      @(posedge clk); #1;
      tick();
      chk("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
      chk("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
      rst = 1'b0;
      idle();
      // IDLE ignores in_valid
      bus.in_valid = 1'b1;
      tick();
      idle();

      // Single ADDI with last
      pulse_start();
      put(10, 1, 0, 0, 32'd5, 1'b1, {1'b1, 32'h00500093});
      idle(); idle();

      // Back-to-back R-type, wrapping through address 255 -> 0
      pulse_start();
      put(0, 3, 1, 2, 32'd0, 1'b0, {1'b1, 32'h002081B3});
      put(1, 3, 1, 2, 32'd0, 1'b0, {1'b1, 32'h402081B3});
      put(7, 4, 5, 6, 32'd0, 1'b1, {1'b1, 32'h4062D233});
      idle(); idle();

      // Store / branch / load
      pulse_start();
      put(13, 0, 1, 2, 32'd8, 1'b0, {1'b1, 32'h0020A423});
      put(14, 0, 1, 2, -32'sd4, 1'b0, {1'b1, 32'hFE208EE3});
      put(12, 5, 0, 0, -32'sd1, 1'b1, {1'b1, 32'hFFF02283});
      idle(); idle();

      // Illegal descriptors consume but do not write
      pulse_start();
      put(11, 1, 1, 0, 32'd2048, 1'b0, 33'd0);
      put(14, 0, 1, 2, 32'd3, 1'b0, 33'd0);
      put(25, 1, 1, 1, 32'd0, 1'b0, 33'd0);
      put(10, 1, 0, 0, 32'd5, 1'b1, {1'b1, 32'h00500093});
      idle(); idle();

      // DEPTH limit: 4 accepted, rest refused
      pulse_start();
      for (int i = 0; i < 4; i++) put(10, i + 1, 0, 0, 32'(i), 1'b0, ref_enc(10, i + 1, 0, 0, 32'(i)));
      chk("ready_low_after_4th", 64'(bus.in_ready), 64'd0);
      for (int i = 0; i < 2; i++) begin
         send(0, 1, 2, 3, 32'd0, 1'b0, ref_enc(0, 1, 2, 3, 0), 3, acc);
         chk("refused_over_depth", 64'(acc), 64'd0);
      end
      idle();

      // start during LOAD is ignored
      pulse_start();
      put(8, 2, 3, 4, 32'd0, 1'b0, ref_enc(8, 2, 3, 4, 0));
      pulse_start();
      put(9, 2, 3, 4, 32'd0, 1'b1, ref_enc(9, 2, 3, 4, 0));
      idle(); idle();

      // Reset right after an accept drops the write
      pulse_start();
      put(10, 7, 0, 0, 32'd9, 1'b0, ref_enc(10, 7, 0, 0, 32'd9));
      bus.in_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_async_we", 64'(bus.imem_we), 64'd0);
      chk("rst_async_count", 64'(count), 64'd0);
      chk("rst_async_addr", 64'(bus.imem_addr), 64'd0);
      chk("rst_async_wdata", 64'(bus.imem_wdata), 64'd0);
      tick();
      rst = 1'b0;
      idle();
      pulse_start();
      put(10, 1, 0, 0, 32'd5, 1'b1, {1'b1, 32'h00500093});
      idle(); idle();

      // Randomized sessions
      for (int s = 0; s < 30; s++) begin
         pulse_start();
         for (int i = 0; i < 7; i++) begin
            if (!m_load) break;
            op  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
            rd  = int'($urandom_range(0, 31));
            rs1 = int'($urandom_range(0, 31));
            rs2 = int'($urandom_range(0, 31));
            imm = rand_imm();
            put(op, rd, rs1, rs2, imm, $urandom_range(0, 5) == 0, ref_enc(op, rd, rs1, rs2, imm));
            if ($urandom_range(0, 2) == 0) idle();
         end
         idle(); idle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Turns operation descriptors into RV32I instruction words and writes them sequentially into instruction memory. It produces the opcode/funct3/funct7/immediate fields that the core's control decoder consumes. It serves as the boot and test loader that fills imem before the core is released from reset. Descriptors arrive on a valid/ready stream; each legal one is encoded and written one cycle after acceptance.

Parameters:
ADDR_W, 8, width of imem word address
BASE_ADDR, 0, first word address written after start
DEPTH, 256, maximum words per load session; legal range 1 to 2^ADDR_W

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; opens a load session
in_valid  input  1  descriptor valid
in_ready  output  1  block can accept a descriptor
in_op  input  5  operation enum (see Decomposition)
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  signed immediate / byte offset
in_last  input  1  descriptor is the final one of the session
imem_we  output  1  write strobe, one cycle per word
imem_addr  output  ADDR_W  write word address
imem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written this session
full  output  1  count == DEPTH
done  output  1  session finished
err_illegal  output  1  sticky; at least one descriptor was rejected

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0; write pointer = BASE_ADDR; any pending write is dropped.
- FSM states:
  - IDLE: in_ready=0. start moves to LOAD and clears count, done, err_illegal and the pointer.
  - LOAD: in_ready = !full. A descriptor is accepted when in_valid && in_ready.
    - Accepted with in_last=1: go to DONE.
    - count reaches DEPTH (full): go to DONE.
    - start while in LOAD: ignored.
  - DONE: done=1, in_ready=0. start re-enters LOAD with count, pointer and errors cleared.
- Write latency: a legal descriptor accepted at edge N appears at edge N+1 as imem_we=1 for exactly one cycle, with imem_addr = pointer and the encoded word on imem_wdata. The pointer and count then increment. A write still pending on entry to DONE completes in the first DONE cycle. Throughput is one descriptor per cycle.
- full is computed from count plus the pending write, so in_ready drops in the same cycle the DEPTH-th descriptor is accepted. No overflow write ever occurs.
- Illegal descriptor: an undefined in_op, or an immediate out of range.
  - The descriptor is consumed and no write is issued.
  - err_illegal is set and the pointer does not advance.
  - If in_last=1, DONE is still entered.
- Encoding:
  - R ops: funct7|rs2|rs1|funct3|rd|0110011. funct7 = 0100000 for SUB and SRA, else 0000000.
  - ADDI and ORI use opcode 0010011; LW uses 0000011. Field order imm[11:0]|rs1|funct3|rd|opcode. funct3: ADDI 000, ORI 110, LW 010.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - Branches: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011.
  - Branch funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - Unused register fields are ignored; rd is not encoded for SW or branches.
- Range rules:
  - I and S types: in_imm[31:11] must be all-equal (12-bit signed).
  - B type: in_imm[31:12] must be all-equal and in_imm[0] must be 0.
- Pointer wraps modulo 2^ADDR_W; this is only reachable when BASE_ADDR+DEPTH > 2^ADDR_W.

Decomposition:
- Package instr_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - funct3/funct7 constants;
  - the op enum: ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND=9, ADDI=10, ORI, LW, SW, BEQ=14, BNE, BLT, BGE, BLTU, BGEU=19. Values 20-31 are illegal.
- Sub-module instr_field_pack: purely combinational op/fields -> {word, illegal}. The parent holds the FSM, pointer, count and output register.

Test Plan:
- start; ADDI x1,x0,5 with in_last -> one imem_we at BASE_ADDR, wdata 0x00500093; count 1; done 1.
- Back-to-back ADD x3,x1,x2; SUB x3,x1,x2; SRA x4,x5,x6 with in_valid held -> words 0x002081B3, 0x402081B3, 0x4062D233 at consecutive addresses on consecutive cycles.
- SW x2,8(x1); BEQ x1,x2,-4; LW x5,-1(x0) -> 0x0020A423, 0xFE208EE3, 0xFFF02283.
- ORI imm=2048, then BEQ imm=3, then in_op=25 -> no writes; err_illegal=1; count unchanged; the next legal op is written at the unadvanced address.
- DEPTH=4 with 6 descriptors offered -> exactly 4 writes; in_ready low from the cycle the 4th is accepted; full=1; done=1.
- Assert rst in the cycle after an accept -> no imem_we; all outputs 0 immediately. A subsequent start writes at BASE_ADDR.
